bounded_counter_bank: RTL and testbench

Parametrised bank of independent bounded step counters for the arithmetic-invariant suite. Each channel holds a count `i`, a programmable limit `y` and a fixed ceiling `X_CEIL`. Each channel steps up toward its limit or down toward zero on a per-channel select. The invariant `0 <= i <= y <= X_CEIL` holds on every cycle and is checked in-block when the checker is compiled in.

---
 rtl/bounded_counter_bank.sv | 127 ++++++++++++
 tb/tb_bounded_counter_bank.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bounded_counter_bank.sv
// bounded_counter_bank: bank of independent bounded step counters.
// Each channel keeps a count i and a limit y with 0 <= i <= y <= X_CEIL.
// A per-channel select steps the count up toward y or down toward 0,
// saturating at either end. A load replaces one channel's limit; if the
// count would exceed the new limit, the count is clamped to it.
// Optional feature macro: BCB_INVARIANT_EN compiles in an invariant checker
// that drives the sticky err flag and emits concurrent assertions;
// without it err is tied low.
module bounded_counter_bank #(
    parameter int WIDTH    = 31,
    parameter int CHANNELS = 4,
    parameter int X_CEIL   = 500,
    parameter int Y_INIT   = 450,
    localparam int LDW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       sel,
    input  logic [CHANNELS-1:0]       dir,
    input  logic                      ld,
    input  logic [LDW-1:0]            ld_ch,
    input  logic [WIDTH-1:0]          ld_val,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       at_lim,
    output logic [CHANNELS-1:0]       at_zero,
    output logic                      err
);

    localparam logic [WIDTH-1:0] CEIL  = WIDTH'(X_CEIL);
    localparam logic [WIDTH-1:0] YINIT = WIDTH'(Y_INIT);

    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    lim_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [WIDTH-1:0]    lim_d [CHANNELS];
    logic [CHANNELS-1:0] ld_hit;
    logic [CHANNELS-1:0] at_lim_d;
    logic [CHANNELS-1:0] at_zero_d;
    logic [WIDTH-1:0]    new_lim;

    // Next-state per channel: load has priority over stepping; steps saturate.
    always_comb begin
        new_lim = (ld_val > CEIL) ? CEIL : ld_val;
        for (int k = 0; k < CHANNELS; k++) begin
            ld_hit[k] = ld && (int'(ld_ch) == k);
            cnt_d[k]  = cnt_q[k];
            lim_d[k]  = lim_q[k];
            if (ld_hit[k]) begin
                lim_d[k] = new_lim;
                if (cnt_q[k] > new_lim) begin
                    cnt_d[k] = new_lim;
                end
            end else if (sel[k] && dir[k] && (cnt_q[k] < lim_q[k])) begin
                cnt_d[k] = cnt_q[k] + WIDTH'(1);
            end else if (sel[k] && !dir[k] && (cnt_q[k] != '0)) begin
                cnt_d[k] = cnt_q[k] - WIDTH'(1);
            end
            at_lim_d[k]  = (cnt_d[k] == lim_d[k]);
            at_zero_d[k] = (cnt_d[k] == '0);
        end
    end

    // State and status registers; status flags are computed from next state
    // so they line up with the registered count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= '0;
                lim_q[k] <= YINIT;
            end
            at_lim  <= (Y_INIT == 0) ? '1 : '0;
            at_zero <= '1;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                cnt_q[k] <= cnt_d[k];
                lim_q[k] <= lim_d[k];
            end
            at_lim  <= at_lim_d;
            at_zero <= at_zero_d;
        end
    end

    // Pack channel counts onto the flat output bus.
    always_comb begin
        count = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            count[k*WIDTH +: WIDTH] = cnt_q[k];
        end
    end

`ifdef BCB_INVARIANT_EN
    logic viol;

    // Flag ordering violations and any change on a channel that was neither
    // selected nor loaded this cycle.
    always_comb begin
        viol = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (cnt_q[k] > lim_q[k]) viol = 1'b1;
            if (lim_q[k] > CEIL) viol = 1'b1;
            if (!sel[k] && !ld_hit[k] &&
                ((cnt_d[k] != cnt_q[k]) || (lim_d[k] != lim_q[k]))) viol = 1'b1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (viol) begin
            err <= 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_prop
        a_cnt_le_lim : assert property (@(posedge clk) disable iff (rst)
            cnt_q[g] <= lim_q[g]);
        a_lim_le_ceil : assert property (@(posedge clk) disable iff (rst)
            lim_q[g] <= CEIL);
        a_quiet_hold : assert property (@(posedge clk) disable iff (rst)
            (!sel[g] && !ld_hit[g]) |=> ($stable(cnt_q[g]) && $stable(lim_q[g])));
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bounded_counter_bank.sv
// Directed testbench for bounded_counter_bank (default parameters).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that applied them.
module tb_bounded_counter_bank;

    localparam int W = 31;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [C-1:0]   sel;
    logic [C-1:0]   dir;
    logic           ld;
    logic [1:0]     ld_ch;
    logic [W-1:0]   ld_val;
    logic [C*W-1:0] count;
    logic [C-1:0]   at_lim;
    logic [C-1:0]   at_zero;
    logic           err;

    int chk  = 0;
    int errs = 0;

    bounded_counter_bank dut (
        .clk(clk), .rst(rst), .sel(sel), .dir(dir), .ld(ld), .ld_ch(ld_ch),
        .ld_val(ld_val), .count(count), .at_lim(at_lim), .at_zero(at_zero), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int cnt(input int k);
        return int'(count[k*W +: W]);
    endfunction

    task automatic test_reset();
        rst = 1'b1; sel = '0; dir = '0; ld = 1'b0; ld_ch = '0; ld_val = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk++;
            if (count !== '0) begin
                errs++; $display("FAIL reset_count got %h exp 0", count);
            end
            chk++;
            if (at_zero !== 4'b1111 || at_lim !== 4'b0000 || err !== 1'b0) begin
                errs++;
                $display("FAIL reset_flags got zero=%b lim=%b err=%b exp 1111 0000 0",
                         at_zero, at_lim, err);
            end
        end
    endtask

    task automatic test_count_up();
        sel = 4'b0001; dir = 4'b0001;
        for (int c = 1; c <= 460; c++) begin
            @(negedge clk);
            chk++;
            if (cnt(0) != ((c < 450) ? c : 450)) begin
                errs++; $display("FAIL up_cnt0 cyc %0d got %0d exp %0d", c, cnt(0),
                                 (c < 450) ? c : 450);
            end
            chk++;
            if (at_lim !== ((c >= 450) ? 4'b0001 : 4'b0000)) begin
                errs++; $display("FAIL up_at_lim cyc %0d got %b", c, at_lim);
            end
        end
        chk++;
        if (cnt(1) != 0 || cnt(2) != 0 || cnt(3) != 0 || at_zero !== 4'b1110) begin
            errs++; $display("FAIL up_others got %0d %0d %0d zero=%b exp 0 0 0 1110",
                             cnt(1), cnt(2), cnt(3), at_zero);
        end
        sel = '0;
    endtask

    task automatic test_load_clamp();
        sel = 4'b0010; dir = 4'b0010;
        repeat (100) @(negedge clk);
        sel = '0;
        chk++;
        if (cnt(1) != 100) begin
            errs++; $display("FAIL clamp_pre got %0d exp 100", cnt(1));
        end
        ld = 1'b1; ld_ch = 2'd1; ld_val = 40;
        @(negedge clk);
        ld = 1'b0;
        chk++;
        if (cnt(1) != 40 || at_lim[1] !== 1'b1) begin
            errs++; $display("FAIL clamp_40 got %0d lim=%b exp 40 1", cnt(1), at_lim[1]);
        end
        ld = 1'b1; ld_val = 900;
        @(negedge clk);
        ld = 1'b0;
        chk++;
        if (cnt(1) != 40 || at_lim[1] !== 1'b0) begin
            errs++; $display("FAIL clamp_900 got %0d lim=%b exp 40 0", cnt(1), at_lim[1]);
        end
        sel = 4'b0010; dir = 4'b0010;
        repeat (465) @(negedge clk);
        sel = '0;
        chk++;
        if (cnt(1) != 500 || at_lim[1] !== 1'b1) begin
            errs++; $display("FAIL ceil_500 got %0d lim=%b exp 500 1", cnt(1), at_lim[1]);
        end
        chk++;
        if (cnt(0) != 450 || cnt(2) != 0) begin
            errs++; $display("FAIL clamp_others got %0d %0d exp 450 0", cnt(0), cnt(2));
        end
    endtask

    task automatic test_load_beats_step();
        sel = 4'b0100; dir = 4'b0100;
        repeat (5) @(negedge clk);
        chk++;
        if (cnt(2) != 5) begin
            errs++; $display("FAIL beat_pre got %0d exp 5", cnt(2));
        end
        ld = 1'b1; ld_ch = 2'd2; ld_val = 200;
        @(negedge clk);
        ld = 1'b0;
        chk++;
        if (cnt(2) != 5 || at_lim[2] !== 1'b0) begin
            errs++; $display("FAIL beat_hold got %0d lim=%b exp 5 0", cnt(2), at_lim[2]);
        end
        repeat (197) @(negedge clk);
        sel = '0;
        chk++;
        if (cnt(2) != 200 || at_lim[2] !== 1'b1) begin
            errs++; $display("FAIL beat_lim200 got %0d lim=%b exp 200 1", cnt(2), at_lim[2]);
        end
    endtask

    task automatic test_down_mixed();
        int exp3 [5] = '{2, 1, 0, 0, 0};
        ld = 1'b1; ld_ch = 2'd0; ld_val = 500;
        @(negedge clk);
        ld = 1'b0;
        chk++;
        if (cnt(0) != 450 || at_lim[0] !== 1'b0) begin
            errs++; $display("FAIL mix_ld0 got %0d lim=%b exp 450 0", cnt(0), at_lim[0]);
        end
        sel = 4'b1000; dir = 4'b1000;
        repeat (3) @(negedge clk);
        chk++;
        if (cnt(3) != 3) begin
            errs++; $display("FAIL mix_pre3 got %0d exp 3", cnt(3));
        end
        sel = 4'b1001; dir = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk++;
            if (cnt(3) != exp3[c] || at_zero[3] !== (exp3[c] == 0)) begin
                errs++; $display("FAIL mix_down3 step %0d got %0d zero=%b exp %0d",
                                 c, cnt(3), at_zero[3], exp3[c]);
            end
            chk++;
            if (cnt(0) != 451 + c) begin
                errs++; $display("FAIL mix_up0 step %0d got %0d exp %0d", c, cnt(0), 451 + c);
            end
        end
        sel = '0;
    endtask

    task automatic test_mid_reset();
        sel = 4'b1111; dir = 4'b1111;
        repeat (50) @(negedge clk);
        chk++;
        if (cnt(0) != 500 || cnt(1) != 500 || cnt(2) != 200 || cnt(3) != 50) begin
            errs++; $display("FAIL mid_pre got %0d %0d %0d %0d exp 500 500 200 50",
                             cnt(0), cnt(1), cnt(2), cnt(3));
        end
        chk++;
        if (at_lim !== 4'b0111 || err !== 1'b0) begin
            errs++; $display("FAIL mid_pre_flags got lim=%b err=%b exp 0111 0", at_lim, err);
        end
        rst = 1'b1; ld = 1'b1; ld_ch = 2'd0; ld_val = 3;
        @(negedge clk);
        rst = 1'b0; ld = 1'b0; sel = '0;
        chk++;
        if (count !== '0 || at_zero !== 4'b1111 || at_lim !== 4'b0000) begin
            errs++; $display("FAIL mid_rst got %h zero=%b lim=%b exp 0 1111 0000",
                             count, at_zero, at_lim);
        end
        sel = 4'b1111;
        repeat (452) @(negedge clk);
        sel = '0;
        chk++;
        if (cnt(0) != 450 || cnt(1) != 450 || cnt(2) != 450 || cnt(3) != 450) begin
            errs++; $display("FAIL mid_lim450 got %0d %0d %0d %0d exp 450 each",
                             cnt(0), cnt(1), cnt(2), cnt(3));
        end
        chk++;
        if (at_lim !== 4'b1111 || err !== 1'b0) begin
            errs++; $display("FAIL mid_final got lim=%b err=%b exp 1111 0", at_lim, err);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_clamp();
        test_load_beats_step();
        test_down_mixed();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end

endmodule
